// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi: run enables, divisor load port and per-channel outputs.
`timescale 1ns/1ps
interface clk_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 25
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] En;
  logic              Sync;
  logic              Load;
  logic [CH_W-1:0]   Ch_sel;
  logic [CNT_W-1:0]  Div_val;
  logic [NUM_CH-1:0] Pend;
  logic [NUM_CH-1:0] Clk_out;
  logic [NUM_CH-1:0] Tick;

  modport master (
    output En, Sync, Load, Ch_sel, Div_val,
    input  Pend, Clk_out, Tick
  );

  modport slave (
    input  En, Sync, Load, Ch_sel, Div_val,
    output Pend, Clk_out, Tick
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: 50% square wave plus rising-edge tick per channel,
// with shadowed divisors that only take effect at a terminal count, Sync or channel park.
`timescale 1ns/1ps
module clk_div_multi #(
  parameter int             NUM_CH   = 4,
  parameter int             CNT_W    = 25,
  parameter logic [CNT_W-1:0] DIV_INIT = 25'd249_999
) (
  input  logic             Clk,
  input  logic             Reset,
  clk_div_multi_if.slave   bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  div_q    [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] clk_q;
  logic [NUM_CH-1:0] tick_q;

  logic [NUM_CH-1:0] restart;
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] hit;

  // Out-of-range Ch_sel never matches any channel index, so the write is dropped.
  always_comb begin
    restart = '0;
    term    = '0;
    hit     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      restart[i] = bus.Sync || !bus.En[i];
      term[i]    = (cnt_q[i] == div_q[i]);
      hit[i]     = bus.Load && (bus.Ch_sel == CH_W'(i));
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        div_q[i]    <= DIV_INIT;
        shadow_q[i] <= DIV_INIT;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (restart[i]) begin
          cnt_q[i]  <= '0;
          clk_q[i]  <= 1'b0;
          tick_q[i] <= 1'b0;
        end else if (term[i]) begin
          cnt_q[i]  <= '0;
          clk_q[i]  <= ~clk_q[i];
          tick_q[i] <= ~clk_q[i];
        end else begin
          cnt_q[i]  <= cnt_q[i] + 1'b1;
          tick_q[i] <= 1'b0;
        end
        // Apply uses the old shadow; a coincident load overrides Pend so it waits for the next boundary.
        if ((restart[i] || term[i]) && pend_q[i]) begin
          div_q[i]  <= shadow_q[i];
          pend_q[i] <= 1'b0;
        end
        if (hit[i]) begin
          shadow_q[i] <= bus.Div_val;
          pend_q[i]   <= 1'b1;
        end
      end
    end
  end

  assign bus.Pend    = pend_q;
  assign bus.Clk_out = clk_q;
  assign bus.Tick    = tick_q;
endmodule
